asrv32_inst_mem: RTL

Wishbone-style instruction-memory responder at the far end of the fetch stage's instruction bus (stb/addr out, inst/ack in). It holds a word-organised program RAM, accepts one fetch request per handshake and returns the instruction with a single-cycle ack after a configurable number of wait states. It supports streaming back-to-back fetches, aborts when the initiator drops strobe during a PC redirect, and has a side-band loader write port for boot and testbench program loading.

---
 rtl/asrv32_inst_mem.sv | 109 ++++++++++
 1 files changed

// File: rtl/asrv32_inst_mem.sv
// asrv32 instruction memory: word RAM behind the fetch bus with
// programmable wait states, strobe-drop abort and a loader write port.
module asrv32_inst_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_stb,
  input  logic [31:0]   i_addr,
  output logic [31:0]   o_inst,
  output logic          o_ack,
  output logic          o_err,
  input  logic          i_ld_we,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [31:0]   i_ld_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] WS_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [30:0] BASE_W = {1'b0, BASE_ADDR[31:2]};

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state;
  logic [3:0]  cnt;
  logic [29:0] lat_word;

  logic        accept;
  logic        fire;
  logic [29:0] rd_word;
  logic [30:0] diff;
  logic        in_rng;
  logic [AW-1:0] idx;

  assign accept = i_stb && (state == IDLE || state == RESP);

  // Zero wait states read straight from the bus address at accept;
  // otherwise the latched address is read at the last wait edge.
  assign fire = (accept && WAIT_STATES == 0) ||
                (state == WAIT && i_stb && cnt == 4'd0);

  assign rd_word = (state == WAIT) ? lat_word : i_addr[31:2];

  // Word-granular offset; bit 30 is the borrow of an address below base.
  assign diff   = {1'b0, rd_word} - BASE_W;
  assign in_rng = !diff[30] && (diff[29:AW] == '0);
  assign idx    = diff[AW-1:0];

  always_ff @(posedge i_clk) begin
    if (i_ld_we) begin
      mem[i_ld_addr] <= i_ld_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_word <= 30'd0;
      o_ack    <= 1'b0;
      o_err    <= 1'b0;
      o_inst   <= 32'd0;
    end else begin
      o_ack <= 1'b0;
      o_err <= 1'b0;
      if (fire) begin
        o_ack  <= 1'b1;
        o_err  <= !in_rng;
        o_inst <= in_rng ? mem[idx] : NOP_INST;
      end
      unique case (state)
        IDLE, RESP: begin
          if (accept) begin
            lat_word <= i_addr[31:2];
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WS_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (!i_stb) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
